calc_memory_unit: RTL
=====================

Name: calc_memory_unit

Overview:
- Downstream stage of the operation mux: consumes its 8-bit final result and implements calculator memory (M+, M-, MR, MC) driven by the board push-buttons.
- Each button gets a 2-flop synchronizer, a debouncer and a press-edge detector.
- Holds an 8-bit saturating memory register.
- Produces a registered display value that shows either the live result or the recalled memory.

Parameters:
- WIDTH, 8, data width of result_in, memory and display.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples required before a key level is accepted (10 ms at 50 MHz). Benches set 4.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- result_in  input  WIDTH  final result from the operation mux (zero-extended for add/sub/div).
- key_n  input  4  raw asynchronous push-buttons, active-low: [0]=M+, [1]=M-, [2]=MR toggle, [3]=MC.
- mem_value  output  WIDTH  current memory register contents.
- display_value  output  WIDTH  registered value for the 7-segment path.
- recall_active  output  1  high while the display shows memory.
- sat_flag  output  1  the last M+/M- saturated.
- op_done  output  1  one-cycle pulse on any accepted memory operation.

Behaviour:
- Reset values (on a clk edge with reset=1):
  - mem_value=0, display_value=0, recall_active=0, sat_flag=0, op_done=0.
  - Synchronizer flops and debounced levels = 1 (released); debounce counters = 0.
  - Reset asserted mid-debounce or mid-press discards all pending state. A key held through reset deassertion generates no event until it is released and pressed again.
- Per key:
  - sync2 is the output of the 2-flop synchronizer.
  - If sync2 equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes sync2 and the counter clears.
  - A press event is a one-cycle pulse when the debounced level goes 1->0. Release generates no event.
- Latency from a clean key_n fall to the event pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles. mem_value and op_done update on the edge after the pulse.
- Bounces shorter than DEBOUNCE_CYCLES never produce events.
- Memory operations, evaluated on the event cycle with result_in sampled on that cycle:
  - MC: mem=0, sat_flag=0.
  - M+: sum = mem + result_in computed at WIDTH+1 bits. If sum > 2^WIDTH-1, mem=2^WIDTH-1 and sat_flag=1; else mem=sum and sat_flag=0.
  - M-: if result_in > mem, mem=0 and sat_flag=1; else mem=mem-result_in and sat_flag=0.
  - MR: recall_active toggles.
  - M+ with result_in=0 is a legal no-op: op_done still pulses and sat_flag clears.
- Simultaneous events in one cycle: exactly one of MC > M+ > M- is applied, by that priority. An MR toggle is applied independently in the same cycle. op_done pulses once.
- Display: display_value <= recall_active_next ? mem_next : result_in, registered every cycle. The display therefore tracks result_in with 1-cycle latency, and shows the post-operation memory on the cycle after an event.
- No FSM beyond the per-key debounce counter/level pairs and the recall toggle bit. Memory writes happen only on event cycles.

Decomposition:
- Package calc_pkg:
  - CALC_WIDTH = 8.
  - Key index constants KEY_MPLUS=0, KEY_MMINUS=1, KEY_MR=2, KEY_MC=3.
  - A typedef for the memory op enum {OP_NONE, OP_MC, OP_MPLUS, OP_MMINUS} used by the priority encoder.
- Sub-module key_debounce:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, key_n_raw, press_pulse, level.
  - Contains the synchronizer, counter and edge detector. Instantiated 4 times.
- Memory arithmetic and display registering stay in calc_memory_unit.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, no keys, result_in=0x2A -> mem_value=0, recall_active=0, display_value=0x2A one cycle after result_in is applied.
- result_in=0x30, clean M+ press -> exactly one op_done pulse 6-7 cycles after key_n[0] falls. Then mem_value=0x30, sat_flag=0. Repeat with 0xE0 -> mem_value=0xFF, sat_flag=1.
- mem=0x10, result_in=0x25, M- -> mem_value=0x00, sat_flag=1. Then result_in=0x05 with M+, then result_in=0x03 with M- -> mem_value=0x02, sat_flag=0.
- key_n[0] bounces 1-3 cycles low/high five times, then stays low -> exactly one M+ event and no event on release.
- MC and M+ debounce-complete in the same cycle with mem=0x40 -> mem_value=0, sat_flag=0, one op_done pulse. MR press -> recall_active=1 and display_value=mem_value; a second MR press -> display follows result_in again.
- M+ held low, reset pulsed for 1 cycle mid-debounce -> no event, mem_value=0. After release and a fresh press -> one event.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator memory unit.
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  // Push-button positions within key_n.
  localparam int KEY_MPLUS  = 0;
  localparam int KEY_MMINUS = 1;
  localparam int KEY_MR     = 2;
  localparam int KEY_MC     = 3;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MC,
    OP_MPLUS,
    OP_MMINUS
  } mem_op_e;

  // Picks a single memory write when several keys fire together: MC > M+ > M-.
  // MR is not a memory write and is handled separately.
  function automatic mem_op_e select_op(input logic [3:0] ev);
    mem_op_e op;
    op = OP_NONE;
    if (ev[KEY_MC])          op = OP_MC;
    else if (ev[KEY_MPLUS])  op = OP_MPLUS;
    else if (ev[KEY_MMINUS]) op = OP_MMINUS;
    return op;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stable-count debouncer and
// press (1->0) edge detector on the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_raw,
  output logic press_pulse,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    settle_q;
  logic          armed_q, armed_d;
  logic          pulse_q, pulse_d;

  // Debounce counter, level update and press detection. A key is only
  // armed once it has been seen released after reset, so a key held
  // through reset cannot produce a spurious press.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // settle_q[1] marks the first cycle where sync2_q reflects the real pin.
    armed_d = armed_q | (settle_q[1] & sync2_q & level_q);
    pulse_d = armed_q & level_q & ~level_d;
  end

  // State registers; reset leaves everything in the released state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      cnt_q    <= '0;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;
  assign level       = level_q;

endmodule

// File: rtl/calc_memory_unit.sv
// Calculator memory (M+, M-, MR, MC) driven by debounced push-buttons,
// with a saturating memory register and a registered display mux.
module calc_memory_unit
  import calc_pkg::*;
#(
  parameter int WIDTH           = CALC_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result_in,
  input  logic [3:0]       key_n,
  output logic [WIDTH-1:0] mem_value,
  output logic [WIDTH-1:0] display_value,
  output logic             recall_active,
  output logic             sat_flag,
  output logic             op_done
);

  logic [3:0]       key_ev;
  logic [3:0]       key_level;
  mem_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             recall_q, recall_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk        (clk),
        .reset      (reset),
        .key_n_raw  (key_n[gi]),
        .press_pulse(key_ev[gi]),
        .level      (key_level[gi])
      );
    end
  endgenerate

  // Memory arithmetic, recall toggle and display selection for this cycle.
  always_comb begin
    op       = select_op(key_ev);
    sum      = {1'b0, mem_q} + {1'b0, result_in};
    mem_d    = mem_q;
    sat_d    = sat_q;
    case (op)
      OP_MC: begin
        mem_d = '0;
        sat_d = 1'b0;
      end
      OP_MPLUS: begin
        if (sum[WIDTH]) begin
          mem_d = '1;
          sat_d = 1'b1;
        end else begin
          mem_d = sum[WIDTH-1:0];
          sat_d = 1'b0;
        end
      end
      OP_MMINUS: begin
        if (result_in > mem_q) begin
          mem_d = '0;
          sat_d = 1'b1;
        end else begin
          mem_d = mem_q - result_in;
          sat_d = 1'b0;
        end
      end
      default: ;
    endcase
    recall_d = recall_q ^ key_ev[KEY_MR];
    done_d   = |key_ev;
    disp_d   = recall_d ? mem_d : result_in;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      disp_q   <= '0;
      recall_q <= 1'b0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      disp_q   <= disp_d;
      recall_q <= recall_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
    end
  end

  assign mem_value     = mem_q;
  assign display_value = disp_q;
  assign recall_active = recall_q;
  assign sat_flag      = sat_q;
  assign op_done       = done_q;

endmodule
